// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the integer register file control path.
package regfile_ctrl_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int NUM_REQ  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid input at or after ptr
// (wrapping modulo N) gets a one-hot grant.
module rr_arbiter #(
    parameter int N    = 3,
    parameter int PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    grant
);

    logic [PtrW:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // ptr < N and i < N, so one conditional subtract wraps the sum.
            idx = {1'b0, ptr} + (PtrW+1)'(i);
            if (idx >= (PtrW+1)'(N)) idx = idx - (PtrW+1)'(N);
            if (!found && valid[idx[PtrW-1:0]]) begin
                grant[idx[PtrW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file write port among NumReq writeback units and tracks
// pending destinations so decode can stall on read-after-write hazards.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int DataWidth  = DATA_W,
    parameter int RegAddress = ADDR_W,
    parameter int NumReq     = NUM_REQ
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumReq-1:0]                    req_valid,
    input  logic [NumReq-1:0][RegAddress-1:0]    req_addr,
    input  logic [NumReq-1:0][DataWidth-1:0]     req_data,
    output logic [NumReq-1:0]                    req_ready,
    input  logic                                 issue_valid,
    input  logic [RegAddress-1:0]                issue_rd,
    input  logic [RegAddress-1:0]                src1,
    input  logic [RegAddress-1:0]                src2,
    output logic                                 hazard,
    output logic                                 wb_en,
    output logic [RegAddress-1:0]                wb_addr,
    output logic [DataWidth-1:0]                 wb_data
);

    localparam int PtrW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int NumRegs = 1 << RegAddress;

    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic                  wb_en_q, wb_en_d;
    logic [RegAddress-1:0] wb_addr_q, wb_addr_d;
    logic [DataWidth-1:0]  wb_data_q, wb_data_d;
    logic [NumRegs-1:0]    pend_q, pend_d;

    logic                  gnt_any;
    logic [PtrW-1:0]       gnt_idx;
    logic [RegAddress-1:0] sel_addr;
    logic [DataWidth-1:0]  sel_data;

    rr_arbiter #(.N(NumReq), .PtrW(PtrW)) u_arb (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (req_ready)
    );

    always_comb begin
        gnt_any  = |req_ready;
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (req_ready[i]) begin
                gnt_idx  = PtrW'(i);
                sel_addr = req_addr[i];
                sel_data = req_data[i];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (gnt_any) begin
            ptr_d     = (gnt_idx == PtrW'(NumReq-1)) ? '0 : gnt_idx + 1'b1;
            // x0 writes are consumed but never reach the register file.
            wb_en_d   = (sel_addr != '0);
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
        end
    end

    // Set applied after clear: a newly issued producer supersedes the retiring one.
    always_comb begin
        pend_d = pend_q;
        if (wb_en_q) pend_d[wb_addr_q] = 1'b0;
        if (issue_valid && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            pend_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            pend_q    <= pend_d;
        end
    end

    assign hazard  = ((src1 != '0) && pend_q[src1]) || ((src2 != '0) && pend_q[src2]);
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for the writeback scheduler: arbitration order, x0 drop,
// scoreboard set/clear, and asynchronous reset.
module tb_regfile_wb_scheduler;
    import regfile_ctrl_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          issue_valid;
    logic [ADDR_W-1:0]             issue_rd, src1, src2;
    logic                          hazard, wb_en;
    logic [ADDR_W-1:0]             wb_addr;
    logic [DATA_W-1:0]             wb_data;

    wb_req_t req [NUM_REQ];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = req[i].addr;
            req_data[i] = req[i].data;
        end
    end

    regfile_wb_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .src1        (src1),
        .src2        (src2),
        .hazard      (hazard),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        src1        = 5'd5;
        src2        = 5'd7;
        req_valid   = 3'b111;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].addr = ADDR_W'(i + 1);
            req[i].data = 32'hA000_0000 + DATA_W'(i + 1);
        end
        #1;
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("rst_hazard", 64'(hazard), 64'd0);
        tick();
        chk("rst_hold_wb_en", 64'(wb_en), 64'd0);
        rst  = 1'b1;
        src1 = '0;
        src2 = '0;
        #1;

        // All three valid: grants rotate 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            tick();
            chk($sformatf("rr_wb_en_%0d", k), 64'(wb_en), 64'd1);
            chk($sformatf("rr_wb_addr_%0d", k), 64'(wb_addr), 64'((k % 3) + 1));
            chk($sformatf("rr_wb_data_%0d", k), 64'(wb_data), 64'(32'hA000_0000 + (k % 3) + 1));
        end
        req_valid = '0;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        tick();
        chk("idle_wb_en", 64'(wb_en), 64'd0);
        chk("idle_wb_addr_hold", 64'(wb_addr), 64'd3);

        // x0 write is granted but suppressed.
        req_valid   = 3'b010;
        req[1].addr = '0;
        req[1].data = 32'hDEADBEEF;
        #1;
        chk("x0_ready", 64'(req_ready), 64'b010);
        tick();
        chk("x0_wb_en", 64'(wb_en), 64'd0);
        req_valid = '0;

        // Scoreboard: issue rd 5, then retire it.
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        src1        = 5'd5;
        #1;
        chk("sb_pre_hazard", 64'(hazard), 64'd0);
        tick();
        issue_valid = 1'b0;
        #1;
        chk("sb_hazard_set", 64'(hazard), 64'd1);
        req_valid   = 3'b001;
        req[0].addr = 5'd5;
        req[0].data = 32'h0000_0055;
        #1;
        chk("sb_ready", 64'(req_ready), 64'b001);
        tick();
        chk("sb_wb_en", 64'(wb_en), 64'd1);
        chk("sb_wb_addr", 64'(wb_addr), 64'd5);
        req_valid = '0;
        tick();
        chk("sb_hazard_clr", 64'(hazard), 64'd0);
        chk("sb_wb_en_off", 64'(wb_en), 64'd0);

        // Set/clear collision on rd 7: set must win.
        src1        = '0;
        src2        = 5'd7;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("col_hazard_set", 64'(hazard), 64'd1);
        req_valid   = 3'b100;
        req[2].addr = 5'd7;
        req[2].data = 32'h0000_0077;
        #1;
        chk("col_ready", 64'(req_ready), 64'b100);
        tick();
        chk("col_wb_addr", 64'(wb_addr), 64'd7);
        req_valid   = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("col_hazard_kept", 64'(hazard), 64'd1);
        tick();
        chk("col_hazard_hold", 64'(hazard), 64'd1);
        req_valid   = 3'b001;
        req[0].addr = 5'd7;
        #1;
        chk("col_ready2", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        tick();
        chk("col_hazard_clr", 64'(hazard), 64'd0);

        // Asynchronous reset while a write is on the port.
        src1        = 5'd12;
        src2        = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        req_valid   = 3'b001;
        req[0].addr = 5'd9;
        req[0].data = 32'h0000_0099;
        tick();
        issue_valid = 1'b0;
        chk("ar_wb_en", 64'(wb_en), 64'd1);
        chk("ar_wb_addr", 64'(wb_addr), 64'd9);
        chk("ar_hazard", 64'(hazard), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_wb_en_drop", 64'(wb_en), 64'd0);
        chk("ar_wb_addr_clr", 64'(wb_addr), 64'd0);
        chk("ar_wb_data_clr", 64'(wb_data), 64'd0);
        chk("ar_hazard_clr", 64'(hazard), 64'd0);
        req_valid = 3'b111;
        rst       = 1'b1;
        #1;
        chk("ar_ready_ptr0", 64'(req_ready), 64'b001);
        tick();
        chk("ar_first_wb_en", 64'(wb_en), 64'd1);
        chk("ar_first_wb_addr", 64'(wb_addr), 64'd9);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
